risc_reg_file: RTL and testbench

//   Operand source and result sink for the RISC execute stage. 32 x 32-bit

---
 rtl/risc_reg_file.sv | 114 +++++++++++
 tb/tb_risc_reg_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/risc_reg_file.sv
// Execute-stage register file: 32 x 32-bit GPRs with two combinational read
// ports and write-to-read bypass, plus HI/LO and a 4-bit ALU flag register.
module risc_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] mult_high_in,
  input  logic [DATA_W-1:0] mult_low_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  output logic [3:0]        flags_out
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [3:0]        flags_q, flags_d;
  logic              wr_valid_s;
  logic              byp_valid_s;

  // Write qualification; bypass is also suppressed while reset is asserted
  always_comb begin
    wr_valid_s  = wr_en && (wr_addr != {ADDR_W{1'b0}});
    byp_valid_s = wr_valid_s && rst_n;
  end

  // Next-state for the GPR array, HI/LO and flags
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_valid_s) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d[0] = {DATA_W{1'b0}};
    end
    regs_d[0] = {DATA_W{1'b0}};

    if (hilo_we) begin
      hi_d = mult_high_in;
      lo_d = mult_low_in;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end

    if (flag_we) begin
      flags_d = flags_in;
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      hi_q    <= {DATA_W{1'b0}};
      lo_q    <= {DATA_W{1'b0}};
      flags_q <= 4'b0000;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flags_q <= flags_d;
    end
  end

  // Read port A: r0 forced to zero, then bypass, then array
  always_comb begin
    rs_data = {DATA_W{1'b0}};
    if (rs_addr == {ADDR_W{1'b0}}) begin
      rs_data = {DATA_W{1'b0}};
    end else if (byp_valid_s && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end else begin
      rs_data = regs_q[rs_addr];
    end
  end

  // Read port B: same rules as port A
  always_comb begin
    rt_data = {DATA_W{1'b0}};
    if (rt_addr == {ADDR_W{1'b0}}) begin
      rt_data = {DATA_W{1'b0}};
    end else if (byp_valid_s && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end else begin
      rt_data = regs_q[rt_addr];
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_risc_reg_file.sv
// Self-checking bench for risc_reg_file: directed scenarios plus randomized
// traffic checked against an array-based architectural model.
module tb_risc_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        wr_en, hilo_we, flag_we;
  logic [31:0] mult_high_in, mult_low_in, hi_out, lo_out;
  logic [3:0]  flags_in, flags_out;

  logic [31:0] m_r [32];
  logic [31:0] m_hi, m_lo;
  logic [3:0]  m_fl;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  risc_reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hilo_we(hilo_we), .mult_high_in(mult_high_in), .mult_low_in(mult_low_in),
    .hi_out(hi_out), .lo_out(lo_out),
    .flag_we(flag_we), .flags_in(flags_in), .flags_out(flags_out)
  );

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_r[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_fl = 4'h0;
  endtask

  // Architectural value seen on a read port in the current cycle
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0 || rst_n !== 1'b1) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_r[a];
  endfunction

  // Advance one clock; commit enabled writes into the model
  task automatic step();
    @(posedge clk);
    if (rst_n === 1'b1) begin
      if (wr_en && wr_addr != 5'd0) m_r[wr_addr] = wr_data;
      if (hilo_we) begin m_hi = mult_high_in; m_lo = mult_low_in; end
      if (flag_we) m_fl = flags_in;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; hilo_we = 1'b0; flag_we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (rs_data !== 32'h0 || hi_out !== 32'h0 || flags_out !== 4'h0)
      $display("FAIL reset_initial rs=%h hi=%h fl=%h expected 0", rs_data, hi_out, flags_out);
    else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    hilo_we = 1'b1; mult_high_in = 32'h11; mult_low_in = 32'h22;
    flag_we = 1'b1; flags_in = 4'hA;
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5; rs_addr = 5'd3; rt_addr = 5'd3;
    idle(); wr_en = 1'b1;
    #2; rst_n = 1'b0; model_clear(); #1;
    total++; if (rs_data !== 32'h0 || rt_data !== 32'h0)
      $display("FAIL reset_async_read rs=%h rt=%h expected 0", rs_data, rt_data);
    else passed++;
    total++; if (hi_out !== 32'h0 || lo_out !== 32'h0 || flags_out !== 4'h0)
      $display("FAIL reset_async_hilo hi=%h lo=%h fl=%h expected 0", hi_out, lo_out, flags_out);
    else passed++;
    step();
    @(negedge clk); rst_n = 1'b1; idle(); #1;
    total++; if (rs_data !== 32'h0)
      $display("FAIL reset_no_residue R3=%h expected 0", rs_data);
    else passed++;
    step();
    total++; if (rs_data !== m_r[3] || m_r[3] !== 32'h0)
      $display("FAIL reset_after_edge R3=%h expected 0", rs_data);
    else passed++;
  endtask

  task automatic test_basic_rw();
    idle(); wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF_FFFE; step();
    wr_addr = 5'd2; wr_data = 32'h4; step();
    idle(); rs_addr = 5'd1; rt_addr = 5'd2; #1;
    total++; if (rs_data !== 32'hFFFF_FFFE)
      $display("FAIL rw_rs got %h expected %h", rs_data, 32'hFFFF_FFFE);
    else passed++;
    total++; if (rt_data !== 32'h4)
      $display("FAIL rw_rt got %h expected %h", rt_data, 32'h4);
    else passed++;
    total++; if (rs_data + rt_data !== 32'h2)
      $display("FAIL rw_alu_sum got %h expected 2", rs_data + rt_data);
    else passed++;
  endtask

  task automatic test_bypass();
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    rs_addr = 5'd7; rt_addr = 5'd7; #1;
    total++; if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF)
      $display("FAIL bypass_same rs=%h rt=%h expected deadbeef", rs_data, rt_data);
    else passed++;
    step(); idle(); #1;
    total++; if (rs_data !== 32'hDEAD_BEEF)
      $display("FAIL bypass_commit R7=%h expected deadbeef", rs_data);
    else passed++;
  endtask

  task automatic test_r0();
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs_addr = 5'd0; #1;
    total++; if (rs_data !== 32'h0)
      $display("FAIL r0_during got %h expected 0", rs_data);
    else passed++;
    step(); idle(); #1;
    total++; if (rs_data !== 32'h0)
      $display("FAIL r0_after got %h expected 0", rs_data);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] old_hi;
    old_hi = m_hi;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h8;
    hilo_we = 1'b1; mult_high_in = 32'hFFFF_FFFF; mult_low_in = 32'hFFFF_FFF8;
    flag_we = 1'b1; flags_in = 4'b1000; rs_addr = 5'd5; #1;
    total++; if (hi_out !== old_hi || flags_out !== m_fl)
      $display("FAIL hilo_no_bypass hi=%h fl=%h expected %h %h", hi_out, flags_out, old_hi, m_fl);
    else passed++;
    step(); idle(); #1;
    total++; if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF8)
      $display("FAIL hilo_commit hi=%h lo=%h expected ffffffff fffffff8", hi_out, lo_out);
    else passed++;
    total++; if (flags_out !== 4'b1000 || rs_data !== 32'h8)
      $display("FAIL flag_gpr_commit fl=%b r5=%h expected 1000 8", flags_out, rs_data);
    else passed++;
  endtask

  task automatic test_hold();
    idle();
    for (int c = 0; c < 10; c++) begin
      wr_addr = 5'($urandom); wr_data = $urandom;
      mult_high_in = $urandom; mult_low_in = $urandom; flags_in = 4'($urandom);
      step();
      total++; if (hi_out !== m_hi || lo_out !== m_lo || flags_out !== m_fl)
        $display("FAIL hold_hilo cyc=%0d hi=%h lo=%h fl=%h expected %h %h %h",
                 c, hi_out, lo_out, flags_out, m_hi, m_lo, m_fl);
      else passed++;
    end
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a); #1;
      total++; if (rs_data !== exp_rd(rs_addr) || rt_data !== exp_rd(rt_addr))
        $display("FAIL hold_reg a=%0d rs=%h rt=%h expected %h %h",
                 a, rs_data, rt_data, exp_rd(rs_addr), exp_rd(rt_addr));
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wr_en = 1'($urandom); hilo_we = 1'($urandom); flag_we = 1'($urandom);
      wr_addr = 5'($urandom_range(0, 7)); wr_data = $urandom;
      rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom);
      mult_high_in = $urandom; mult_low_in = $urandom; flags_in = 4'($urandom);
      #1;
      total++; if (rs_data !== exp_rd(rs_addr) || rt_data !== exp_rd(rt_addr))
        $display("FAIL rand_read cyc=%0d rs=%h rt=%h expected %h %h",
                 c, rs_data, rt_data, exp_rd(rs_addr), exp_rd(rt_addr));
      else passed++;
      total++; if (hi_out !== m_hi || lo_out !== m_lo || flags_out !== m_fl)
        $display("FAIL rand_hilo cyc=%0d hi=%h lo=%h fl=%h expected %h %h %h",
                 c, hi_out, lo_out, flags_out, m_hi, m_lo, m_fl);
      else passed++;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; idle();
    rs_addr = 5'd0; rt_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'h0;
    mult_high_in = 32'h0; mult_low_in = 32'h0; flags_in = 4'h0;
    model_clear();
    test_reset();
    test_basic_rw();
    test_bypass();
    test_r0();
    test_simultaneous();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
